// File: rtl/clusterv_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : clusterv_cfg_loader
// Brief    : Drives the tile configuration scan chain. Host words arrive on
//            a valid/ready port, are double-buffered (hold -> sreg) and
//            shifted LSB-first into the chain with a gated-clock enable.
//            Bits returning from the far end of the chain are reassembled
//            into readback words.
// Options  : CLUSTERV_CFG_READBACK_EN - include the readback deserializer.
//            When undefined, rd_valid/rd_dat are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module clusterv_cfg_loader #(
  parameter int N_TILES = 4,
  parameter int WCNT_W  = $clog2(2*N_TILES+1)
) (
  input  logic        cfg_sclk,
  input  logic        sys_reset,
  input  logic        start,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_dat,
  input  logic        wr_last,
  output logic        chain_sdo,
  output logic        chain_en,
  input  logic        chain_sdi,
  output logic        rd_valid,
  output logic [31:0] rd_dat,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [WCNT_W-1:0] N_WORDS   = WCNT_W'(2*N_TILES);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(2*N_TILES-1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t            state;
  logic [WCNT_W-1:0] wcnt_in;
  logic [WCNT_W-1:0] wcnt_out;
  logic [31:0]       hold;
  logic              hold_full;
  logic [31:0]       sreg;
  logic              sh_vld;
  logic [4:0]        bcnt;

  logic              accept;
  logic              word_end;
  logic              final_shift;

  // All handshake and chain outputs are decoded from flops only, so the
  // host and the clock gate never see a combinational path from inputs.
  assign wr_ready    = (state == ACTIVE) && !hold_full && (wcnt_in < N_WORDS);
  assign accept      = wr_valid && wr_ready;
  assign word_end    = sh_vld && (bcnt == 5'd31);
  assign final_shift = word_end && (wcnt_out == LAST_WORD);
  assign busy        = (state == ACTIVE);
  assign chain_sdo   = sreg[0];
  assign chain_en    = sh_vld;

  // Sequence control, host word buffer and serializer.
  always_ff @(posedge cfg_sclk or posedge sys_reset) begin
    if (sys_reset) begin
      state     <= IDLE;
      wcnt_in   <= '0;
      wcnt_out  <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      sreg      <= '0;
      sh_vld    <= 1'b0;
      bcnt      <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACTIVE;
            wcnt_in  <= '0;
            wcnt_out <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end
        ACTIVE: begin
          // start is deliberately ignored here.
          if (final_shift) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Host side: hold is only written while empty, so it never collides
      // with the serializer draining it below.
      if (accept) begin
        hold      <= wr_dat;
        hold_full <= 1'b1;
        wcnt_in   <= wcnt_in + WCNT_W'(1);
        // wr_last must mark exactly the final word of the load.
        if (wr_last != (wcnt_in == LAST_WORD)) begin
          err <= 1'b1;
        end
      end

      // Serializer: back-to-back words when hold is ready, otherwise stop
      // the gated clock so the chain simply waits without losing a bit.
      if (sh_vld) begin
        sreg <= {1'b0, sreg[31:1]};
        bcnt <= bcnt + 5'd1;
        if (word_end) begin
          wcnt_out <= wcnt_out + WCNT_W'(1);
          if (hold_full) begin
            sreg      <= hold;
            hold_full <= 1'b0;
          end else begin
            sh_vld <= 1'b0;
          end
        end
      end else if (hold_full) begin
        sreg      <= hold;
        sh_vld    <= 1'b1;
        bcnt      <= '0;
        hold_full <= 1'b0;
      end
    end
  end

`ifdef CLUSTERV_CFG_READBACK_EN
  // rsh keeps only the 31 bits still needed; the 32nd arrives live on
  // chain_sdi in the edge that completes the word.
  logic [30:0] rsh;
  logic [4:0]  rcnt;

  // Deserialize bits leaving the last tile, one per gated chain edge.
  always_ff @(posedge cfg_sclk or posedge sys_reset) begin
    if (sys_reset) begin
      rsh      <= '0;
      rcnt     <= '0;
      rd_dat   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (sh_vld) begin
        rsh  <= {chain_sdi, rsh[30:1]};
        rcnt <= rcnt + 5'd1;
        if (rcnt == 5'd31) begin
          rd_dat   <= {chain_sdi, rsh};
          rd_valid <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_chain_sdi;
  assign unused_chain_sdi = chain_sdi;
  assign rd_valid         = 1'b0;
  assign rd_dat           = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clusterv_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_clusterv_cfg_loader
// Brief    : Bench for clusterv_cfg_loader with a 2-tile scan chain model.
//            Load scenarios come from a vector table; readback words are
//            predicted from the chain model and checked through a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clusterv_cfg_loader;

  localparam int N_TILES = 2;
  localparam int N_WORDS = 2*N_TILES;
  localparam int CHAIN   = 64*N_TILES;
`ifdef CLUSTERV_CFG_READBACK_EN
  localparam int EXP_RD = N_WORDS;
`else
  localparam int EXP_RD = 0;
`endif

  logic        cfg_sclk = 1'b0;
  logic        sys_reset;
  logic        start;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_dat;
  logic        wr_last;
  logic        chain_sdo;
  logic        chain_en;
  logic        chain_sdi;
  logic        rd_valid;
  logic [31:0] rd_dat;
  logic        busy;
  logic        done;
  logic        err;

  clusterv_cfg_loader #(.N_TILES(N_TILES)) dut (
    .cfg_sclk (cfg_sclk),
    .sys_reset(sys_reset),
    .start    (start),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_dat   (wr_dat),
    .wr_last  (wr_last),
    .chain_sdo(chain_sdo),
    .chain_en (chain_en),
    .chain_sdi(chain_sdi),
    .rd_valid (rd_valid),
    .rd_dat   (rd_dat),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 cfg_sclk = ~cfg_sclk;

  // Chain model: bit 0 is the last tile's cfg_sdo. After a full load,
  // chain[32k +: 32] holds host word k (tile1 hartid, tile1 resvec, ...).
  logic [CHAIN-1:0] chain;
  assign chain_sdi = chain[0];

  always @(posedge cfg_sclk or posedge sys_reset) begin
    if (sys_reset)     chain <= {(2*N_TILES){32'h8000_0000}};
    else if (chain_en) chain <= {chain_sdo, chain[CHAIN-1:1]};
  end

  int tests = 0;
  int fails = 0;
  int en_cnt, bursts, rd_cnt;
  logic prev_en = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out", name);
  endtask

  // Output monitor: gated-clock activity and readback scoreboard.
  always @(negedge cfg_sclk) begin
    if (chain_en) begin
      en_cnt++;
      if (!prev_en) bursts++;
    end
    prev_en = chain_en;
    if (rd_valid) begin
      rd_cnt++;
      if (exp_q.size() == 0) fail_now("rd_unexpected");
      else check("rd_dat", rd_dat, exp_q.pop_front());
    end
  end

  typedef struct packed {
    logic [95:0]       name;
    logic [3:0][31:0]  w;
    logic [2:0]        last_idx;   // 4 = wr_last never asserted
    logic [2:0]        stall_idx;  // 4 = no stall
    logic [7:0]        stall;      // idle cycles after wr_ready rises
    logic              restart;    // pulse start mid-load (must be ignored)
    logic              exp_err;
    logic [3:0]        exp_bursts;
  } vec_t;

  function automatic vec_t mk(input logic [95:0] name,
                              input logic [31:0] a, b, c, d,
                              input int last_idx, stall_idx, stall,
                              input bit restart, exp_err, input int bursts);
    mk.name       = name;
    mk.w[0]       = a;
    mk.w[1]       = b;
    mk.w[2]       = c;
    mk.w[3]       = d;
    mk.last_idx   = 3'(last_idx);
    mk.stall_idx  = 3'(stall_idx);
    mk.stall      = 8'(stall);
    mk.restart    = restart;
    mk.exp_err    = exp_err;
    mk.exp_bursts = 4'(bursts);
  endfunction

  vec_t vecs[6];

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic last, output bit ok);
    ok       = 1'b0;
    wr_valid = 1'b1;
    wr_dat   = d;
    wr_last  = last;
    for (int t = 0; t < 400; t++) begin
      if (wr_ready) begin ok = 1'b1; break; end
      @(negedge cfg_sclk);
    end
    if (ok) @(negedge cfg_sclk);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic run_row(input vec_t v);
    bit ok;
    string nm;
    string tn[4];
    nm = $sformatf("%0s", v.name);
    tn[0] = "tile1_hartid"; tn[1] = "tile1_resvec";
    tn[2] = "tile0_hartid"; tn[3] = "tile0_resvec";
    en_cnt = 0; bursts = 0; rd_cnt = 0;
`ifdef CLUSTERV_CFG_READBACK_EN
    for (int k = 0; k < N_WORDS; k++) exp_q.push_back(chain[32*k +: 32]);
`endif
    start = 1'b1;
    @(negedge cfg_sclk);
    start = 1'b0;
    check({nm, "_busy_on_start"}, 32'(busy), 32'd1);
    for (int k = 0; k < N_WORDS; k++) begin
      if (k == int'(v.stall_idx)) begin
        for (int t = 0; t < 400 && !wr_ready; t++) @(negedge cfg_sclk);
        repeat (int'(v.stall)) @(negedge cfg_sclk);
      end
      send_word(v.w[k], (k == int'(v.last_idx)), ok);
      if (!ok) begin fail_now({nm, "_accept"}); return; end
      if (v.restart && k == 1) begin
        start = 1'b1;
        @(negedge cfg_sclk);
        start = 1'b0;
      end
    end
    for (int t = 0; t < 400 && !done; t++) @(negedge cfg_sclk);
    @(negedge cfg_sclk);
    check({nm, "_done"},     32'(done),     32'd1);
    check({nm, "_err"},      32'(err),      32'(v.exp_err));
    check({nm, "_busy_end"}, 32'(busy),     32'd0);
    check({nm, "_en_cnt"},   32'(en_cnt),   32'(CHAIN));
    check({nm, "_bursts"},   32'(bursts),   32'(v.exp_bursts));
    check({nm, "_rd_cnt"},   32'(rd_cnt),   32'(EXP_RD));
    for (int k = 0; k < N_WORDS; k++)
      check({nm, "_", tn[k]}, chain[32*k +: 32], v.w[k]);
`ifndef CLUSTERV_CFG_READBACK_EN
    check({nm, "_rd_dat_zero"}, rd_dat, 32'd0);
`endif
  endtask

  initial begin
    bit ok;
    sys_reset = 1'b1;
    start     = 1'b0;
    wr_valid  = 1'b0;
    wr_dat    = '0;
    wr_last   = 1'b0;

    vecs[0] = mk("nominal",  32'h8000_0000, 32'h2000_0000, 32'h8000_0001, 32'h2000_0100, 3, 4, 0,  0, 0, 1);
    vecs[1] = mk("stall10",  32'h8000_0000, 32'h2000_0000, 32'h8000_0001, 32'h2000_0100, 3, 2, 10, 0, 0, 1);
    vecs[2] = mk("stall45",  32'h8000_0000, 32'h2000_0000, 32'h8000_0001, 32'h2000_0100, 3, 2, 45, 0, 0, 2);
    vecs[3] = mk("last_w2",  32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888, 1, 4, 0,  0, 1, 1);
    vecs[4] = mk("no_last",  32'hCAFE_F00D, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 4, 4, 0,  0, 1, 1);
    vecs[5] = mk("restart",  32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_A5A5, 32'h0F0F_0F01, 3, 4, 0,  1, 0, 1);

    repeat (3) @(negedge cfg_sclk);
    check("reset_flags", {25'd0, busy, done, err, wr_ready, chain_en, chain_sdo, rd_valid}, 32'd0);
    sys_reset = 1'b0;
    @(negedge cfg_sclk);
    check("idle_flags", {25'd0, busy, done, err, wr_ready, chain_en, chain_sdo, rd_valid}, 32'd0);
    check("idle_rd_dat", rd_dat, 32'd0);

    // Host pushing without start must be ignored.
    wr_valid = 1'b1;
    wr_dat   = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      @(negedge cfg_sclk);
      check("nostart_ready_en", {30'd0, wr_ready, chain_en}, 32'd0);
    end
    wr_valid = 1'b0;
    @(negedge cfg_sclk);

    for (int i = 0; i < 6; i++) run_row(vecs[i]);

    // Abort after ~40 shift cycles, then recover with a clean load.
    en_cnt = 0;
    start = 1'b1;
    @(negedge cfg_sclk);
    start = 1'b0;
    send_word(32'h0BAD_0BAD, 1'b0, ok);
    send_word(32'h0BAD_1BAD, 1'b0, ok);
    for (int t = 0; t < 200 && en_cnt < 40; t++) @(negedge cfg_sclk);
    check("abort_reached_40", 32'(en_cnt >= 40), 32'd1);
    sys_reset = 1'b1;
    @(negedge cfg_sclk);
    check("abort_flags", {27'd0, busy, chain_en, wr_ready, done, err}, 32'd0);
    exp_q.delete();
    sys_reset = 1'b0;
    @(negedge cfg_sclk);
    run_row(vecs[0]);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
